btb_assoc: RTL and testbench

Parametrised set-associative branch target buffer for the fetch stage. Lookup is combinational and returns hit, branch/jump type and target for the fetch PC. Decoded branches and jumps from ID update it, with tree pseudo-LRU replacement per set. A sequential walker invalidates every set after reset and on flush request.

---
 rtl/btb_pkg.sv | 37 +++
 rtl/btb_plru.sv | 47 ++++
 rtl/btb_assoc.sv | 203 ++++++++++++++++++++
 tb/tb_btb_assoc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btb_pkg : shared constants, entry layout and walker states for BTB   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package btb_pkg;

   localparam int PC_OFS = 2;

   // Entry layout of the default geometry; the top stores fields per array
   // so that TAG_WIDTH/ADDR_WIDTH can be overridden per instance.
   localparam int BTB_TAG_WIDTH  = 10;
   localparam int BTB_ADDR_WIDTH = 32;

   typedef struct packed {
      logic                      valid;
      logic [BTB_TAG_WIDTH-1:0]  tag;
      logic                      is_jump;
      logic [BTB_ADDR_WIDTH-1:0] target;
      logic [1:0]                counter;
   } btb_entry_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WALK = 1'b1
   } walk_state_e;

   function automatic int plru_width(input int ways);
      return ways - 1;
   endfunction

   function automatic int plru_store_width(input int ways);
      return (ways > 1) ? plru_width(ways) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btb_plru.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btb_plru : combinational tree pseudo-LRU (victim select and touch)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module btb_plru
   import btb_pkg::*;
#(
   parameter  int WAYS = 2,
   localparam int PW   = plru_store_width(WAYS),
   localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic [PW-1:0] plru_i,
   input  logic [WW-1:0] touch_way_i,
   input  logic          touch_en_i,
   output logic [PW-1:0] plru_o,
   output logic [WW-1:0] victim_o
);

   generate
      if (WAYS == 4) begin : g_tree4
         // bit0 picks the pair, bit1/bit2 pick within pair {0,1}/{2,3}
         always_comb begin
            victim_o = plru_i[0] ? {1'b1, plru_i[2]} : {1'b0, plru_i[1]};
            plru_o   = plru_i;
            if (touch_en_i) begin
               plru_o[0] = ~touch_way_i[1];
               if (touch_way_i[1]) begin
                  plru_o[2] = ~touch_way_i[0];
               end else begin
                  plru_o[1] = ~touch_way_i[0];
               end
            end
         end
      end else if (WAYS == 2) begin : g_tree2
         assign victim_o = plru_i;
         assign plru_o   = touch_en_i ? ~touch_way_i : plru_i;
      end else begin : g_direct
         logic w_unused;
         assign w_unused = ^{plru_i, touch_way_i, touch_en_i};
         assign victim_o = '0;
         assign plru_o   = '0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/btb_assoc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btb_assoc : set-associative BTB, PLRU replacement, flush walker.     |
// | Option macro BTB_COUNTER_EN adds 2-bit taken counters.  Rev 1.0      |
// +----------------------------------------------------------------------+
module btb_assoc
   import btb_pkg::*;
#(
   parameter int SETS       = 64,
   parameter int WAYS       = 2,
   parameter int TAG_WIDTH  = 10,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_req,
   output logic                  flush_busy,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   output logic                  hit_out,
   output logic                  is_jump_out,
   output logic                  taken_out,
   output logic [ADDR_WIDTH-1:0] target_out,
   input  logic                  update_en,
   input  logic [ADDR_WIDTH-1:0] update_pc,
   input  logic                  update_is_jump,
   input  logic                  update_taken,
   input  logic [ADDR_WIDTH-1:0] update_target
);

   localparam int IDX_W     = $clog2(SETS);
   localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int PLRU_W    = plru_store_width(WAYS);
   localparam int FIELD_TOP = PC_OFS + IDX_W + TAG_WIDTH;

   logic [WAYS-1:0]       valid_q [SETS];
   logic [WAYS-1:0]       jump_q  [SETS];
   logic [TAG_WIDTH-1:0]  tag_q   [SETS][WAYS];
   logic [ADDR_WIDTH-1:0] tgt_q   [SETS][WAYS];
   logic [PLRU_W-1:0]     plru_q  [SETS];

   walk_state_e      state_q, state_d;
   logic [IDX_W-1:0] walk_idx_q, walk_idx_d;

   logic [IDX_W-1:0]     w_lk_idx, w_up_idx;
   logic [TAG_WIDTH-1:0] w_lk_tag, w_up_tag;
   logic                 w_upd, w_eff_taken, w_wr, w_inval;
   logic                 w_up_hit, w_inv_found;
   logic [WAY_W-1:0]     w_hit_way, w_inv_way, w_victim, w_wr_way;
   logic [PLRU_W-1:0]    w_plru_next;

   assign w_lk_idx = pc_in[PC_OFS +: IDX_W];
   assign w_lk_tag = pc_in[PC_OFS + IDX_W +: TAG_WIDTH];
   assign w_up_idx = update_pc[PC_OFS +: IDX_W];
   assign w_up_tag = update_pc[PC_OFS + IDX_W +: TAG_WIDTH];

   logic w_unused_lo;
   assign w_unused_lo = ^{pc_in[PC_OFS-1:0], update_pc[PC_OFS-1:0]};

   generate
      if (ADDR_WIDTH > FIELD_TOP) begin : g_pc_hi
         logic w_unused_hi;
         assign w_unused_hi = ^{pc_in[ADDR_WIDTH-1:FIELD_TOP],
                                update_pc[ADDR_WIDTH-1:FIELD_TOP]};
      end
   endgenerate

   // ---------------- walker ----------------
   assign flush_busy = (state_q == ST_WALK);

   always_comb begin
      state_d    = state_q;
      walk_idx_d = walk_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_req) begin
               state_d    = ST_WALK;
               walk_idx_d = '0;
            end
         end
         ST_WALK: begin
            if (walk_idx_q == IDX_W'(SETS - 1)) begin
               state_d = ST_IDLE;
            end else begin
               walk_idx_d = walk_idx_q + IDX_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_WALK;
         walk_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         walk_idx_q <= walk_idx_d;
      end
   end

   // ---------------- update path ----------------
   assign w_upd       = update_en & ~flush_busy;
   assign w_eff_taken = update_taken | update_is_jump;

   always_comb begin
      w_up_hit    = 1'b0;
      w_hit_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w_up_idx][w] && (tag_q[w_up_idx][w] == w_up_tag)) begin
            w_up_hit  = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
      // descending scan so the lowest invalid way wins
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w_up_idx][w]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(w);
         end
      end
   end

   assign w_wr_way = w_up_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_victim);

`ifdef BTB_COUNTER_EN
   assign w_wr    = w_up_hit | w_eff_taken;
   assign w_inval = 1'b0;

   logic [1:0] cnt_q [SETS][WAYS];
   logic [1:0] w_cnt_cur, w_cnt_d;

   assign w_cnt_cur = cnt_q[w_up_idx][w_hit_way];

   always_comb begin
      w_cnt_d = w_cnt_cur;
      if (!w_up_hit) begin
         w_cnt_d = w_eff_taken ? 2'b10 : 2'b01;
      end else if (w_eff_taken) begin
         if (w_cnt_cur != 2'b11) w_cnt_d = w_cnt_cur + 2'd1;
      end else if (w_cnt_cur != 2'b00) begin
         w_cnt_d = w_cnt_cur - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_upd && w_wr) begin
         cnt_q[w_up_idx][w_wr_way] <= w_cnt_d;
      end
   end
`else
   assign w_wr    = w_eff_taken;
   assign w_inval = w_up_hit & ~w_eff_taken;
`endif

   btb_plru #(
      .WAYS (WAYS)
   ) u_plru (
      .plru_i      (plru_q[w_up_idx]),
      .touch_way_i (w_wr_way),
      .touch_en_i  (w_upd & w_wr),
      .plru_o      (w_plru_next),
      .victim_o    (w_victim)
   );

   always_ff @(posedge clk) begin
      if (flush_busy) begin
         valid_q[walk_idx_q] <= '0;
         plru_q[walk_idx_q]  <= '0;
      end else if (w_upd && w_wr) begin
         valid_q[w_up_idx][w_wr_way] <= 1'b1;
         jump_q[w_up_idx][w_wr_way]  <= update_is_jump;
         tag_q[w_up_idx][w_wr_way]   <= w_up_tag;
         tgt_q[w_up_idx][w_wr_way]   <= update_target;
         plru_q[w_up_idx]            <= w_plru_next;
      end else if (w_upd && w_inval) begin
         valid_q[w_up_idx][w_wr_way] <= 1'b0;
      end
   end

   // ---------------- lookup (reads pre-update state) ----------------
   always_comb begin
      hit_out     = 1'b0;
      is_jump_out = 1'b0;
      taken_out   = 1'b0;
      target_out  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!flush_busy && valid_q[w_lk_idx][w] && (tag_q[w_lk_idx][w] == w_lk_tag)) begin
            hit_out     = 1'b1;
            is_jump_out = jump_q[w_lk_idx][w];
            target_out  = tgt_q[w_lk_idx][w];
`ifdef BTB_COUNTER_EN
            taken_out   = jump_q[w_lk_idx][w] | cnt_q[w_lk_idx][w][1];
`else
            taken_out   = 1'b1;
`endif
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_btb_assoc : table-driven, scoreboarded bench for btb_assoc        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_btb_assoc;

   logic        clk;
   logic        rst;
   logic        flush_req;
   logic        flush_busy;
   logic [31:0] pc_in;
   logic        hit_out;
   logic        is_jump_out;
   logic        taken_out;
   logic [31:0] target_out;
   logic        update_en;
   logic [31:0] update_pc;
   logic        update_is_jump;
   logic        update_taken;
   logic [31:0] update_target;

   btb_assoc #(
      .SETS       (64),
      .WAYS       (2),
      .TAG_WIDTH  (10),
      .ADDR_WIDTH (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush_req      (flush_req),
      .flush_busy     (flush_busy),
      .pc_in          (pc_in),
      .hit_out        (hit_out),
      .is_jump_out    (is_jump_out),
      .taken_out      (taken_out),
      .target_out     (target_out),
      .update_en      (update_en),
      .update_pc      (update_pc),
      .update_is_jump (update_is_jump),
      .update_taken   (update_taken),
      .update_target  (update_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        upd;
      logic [31:0] upc;
      logic        uj;
      logic        ut;
      logic [31:0] utgt;
      logic [31:0] lpc;
      logic        ehit;
      logic        ej;
      logic        et;
      logic [31:0] etgt;
   } vec_t;

   vec_t        vecs[$];
   logic [34:0] exp_q[$];
   int          n_vec  = 0;
   int          n_fail = 0;
   int          cyc;
   int          bad;

   function automatic vec_t mk(input logic upd, input logic [31:0] upc, input logic uj,
                               input logic ut, input logic [31:0] utgt, input logic [31:0] lpc,
                               input logic ehit, input logic ej, input logic et,
                               input logic [31:0] etgt);
      vec_t v;
      v.upd = upd; v.upc = upc; v.uj = uj; v.ut = ut; v.utgt = utgt;
      v.lpc = lpc; v.ehit = ehit; v.ej = ej; v.et = et; v.etgt = etgt;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic logic [34:0] outs();
      return {hit_out, is_jump_out, taken_out, target_out};
   endfunction

   task automatic look(input string name, input logic [31:0] pc, input logic [34:0] exp);
      @(negedge clk);
      pc_in = pc;
      exp_q.push_back(exp);
      #1;
      check(name, 64'(outs()), 64'(exp_q.pop_front()));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; flush_req = 1'b0; pc_in = 32'h0000_1000;
      update_en = 1'b0; update_pc = '0; update_is_jump = 1'b0;
      update_taken = 1'b0; update_target = '0;

      // ---- reset and initial walk ----
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 64'(flush_busy), 64'd1);
      check("rst_lookup", 64'(outs()), 64'd0);
      rst = 1'b1;
      cyc = 0; bad = 0;
      while (flush_busy === 1'b1 && cyc < 200) begin
         if (outs() !== 35'd0) bad++;
         cyc++;
         @(negedge clk); #1;
      end
      check("rst_busy_cycles", 64'(cyc), 64'd64);
      check("rst_window_outputs", 64'(bad), 64'd0);

      // ---- vector table: lookup sees contents before same-cycle update ----
      vecs.push_back(mk(1, 32'h1004, 1, 1, 32'h2000, 32'h1004, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h1004, 1, 1, 1, 32'h2000));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h1008, 0, 0, 0, 32'h0));
      vecs.push_back(mk(1, 32'h1004, 0, 1, 32'h1100, 32'h1004, 1, 1, 1, 32'h2000));
      vecs.push_back(mk(1, 32'h2004, 0, 1, 32'h2200, 32'h1004, 1, 0, 1, 32'h1100));
      vecs.push_back(mk(1, 32'h3004, 0, 1, 32'h3300, 32'h2004, 1, 0, 1, 32'h2200));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h1004, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h2004, 1, 0, 1, 32'h2200));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h3004, 1, 0, 1, 32'h3300));
      vecs.push_back(mk(1, 32'h4004, 0, 1, 32'h4400, 32'h3004, 1, 0, 1, 32'h3300));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h2004, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h4004, 1, 0, 1, 32'h4400));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h3004, 1, 0, 1, 32'h3300));
      // last set, ignored low bits, tag bit 9, ignored bits above the tag
      vecs.push_back(mk(1, 32'h00FC, 1, 1, 32'h0ABC, 32'h00FC, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h00FF, 1, 1, 1, 32'h0ABC));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0002_00FC, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0004_00FC, 1, 1, 1, 32'h0ABC));
      vecs.push_back(mk(1, 32'h7008, 0, 0, 32'h7700, 32'h7008, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h7008, 0, 0, 0, 32'h0));
`ifdef BTB_COUNTER_EN
      vecs.push_back(mk(1, 32'h5008, 0, 1, 32'h5500, 32'h5008, 0, 0, 0, 32'h0));
      vecs.push_back(mk(1, 32'h5008, 0, 0, 32'h5500, 32'h5008, 1, 0, 1, 32'h5500));
      vecs.push_back(mk(1, 32'h5008, 0, 0, 32'h5500, 32'h5008, 1, 0, 0, 32'h5500));
      vecs.push_back(mk(1, 32'h5008, 0, 0, 32'h5500, 32'h5008, 1, 0, 0, 32'h5500));
      vecs.push_back(mk(1, 32'h5008, 0, 1, 32'h5500, 32'h5008, 1, 0, 0, 32'h5500));
      vecs.push_back(mk(1, 32'h5008, 0, 1, 32'h5500, 32'h5008, 1, 0, 0, 32'h5500));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h5008, 1, 0, 1, 32'h5500));
`else
      vecs.push_back(mk(1, 32'h5008, 0, 1, 32'h5500, 32'h5008, 0, 0, 0, 32'h0));
      vecs.push_back(mk(1, 32'h5008, 0, 0, 32'h5500, 32'h5008, 1, 0, 1, 32'h5500));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h5008, 0, 0, 0, 32'h0));
      vecs.push_back(mk(1, 32'h5008, 0, 0, 32'h5500, 32'h5008, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h5008, 0, 0, 0, 32'h0));
`endif
      vecs.push_back(mk(1, 32'h6008, 1, 0, 32'h6600, 32'h6008, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h6008, 1, 1, 1, 32'h6600));

      foreach (vecs[i]) begin
         @(negedge clk);
         update_en      = vecs[i].upd;
         update_pc      = vecs[i].upc;
         update_is_jump = vecs[i].uj;
         update_taken   = vecs[i].ut;
         update_target  = vecs[i].utgt;
         pc_in          = vecs[i].lpc;
         exp_q.push_back({vecs[i].ehit, vecs[i].ej, vecs[i].et, vecs[i].etgt});
         #1;
         check($sformatf("vec%0d pc=%h", i, vecs[i].lpc), 64'(outs()), 64'(exp_q.pop_front()));
      end
      @(negedge clk);
      update_en = 1'b0;

      // ---- flush: update in the request cycle lands, then gets walked away ----
      @(negedge clk);
      flush_req = 1'b1; update_en = 1'b1; update_pc = 32'h0200;
      update_is_jump = 1'b1; update_taken = 1'b1; update_target = 32'h0777;
      pc_in = 32'h00FC;
      #1;
      check("flush_pre_hit", 64'(outs()), 64'({1'b1, 1'b1, 1'b1, 32'h0ABC}));
      @(negedge clk);
      flush_req = 1'b0; update_en = 1'b0;
      #1;
      cyc = 0; bad = 0;
      update_pc = 32'h0100; update_target = 32'h0888;
      while (flush_busy === 1'b1 && cyc < 200) begin
         if (outs() !== 35'd0) bad++;
         cyc++;
         @(negedge clk);
         flush_req = (cyc == 10);
         update_en = (cyc == 40);
         #1;
      end
      flush_req = 1'b0; update_en = 1'b0;
      check("flush_busy_cycles", 64'(cyc), 64'd64);
      check("flush_window_outputs", 64'(bad), 64'd0);
      look("flush_clr_3004", 32'h3004, 35'd0);
      look("flush_clr_00fc", 32'h00FC, 35'd0);
      look("flush_req_cycle_upd", 32'h0200, 35'd0);
      look("flush_dropped_upd", 32'h0100, 35'd0);

      // ---- updates work again after the walk ----
      @(negedge clk);
      update_en = 1'b1; update_pc = 32'h1004; update_is_jump = 1'b1;
      update_taken = 1'b1; update_target = 32'h2468;
      @(negedge clk);
      update_en = 1'b0;
      look("post_flush_alloc", 32'h1004, {1'b1, 1'b1, 1'b1, 32'h2468});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
